// File: rtl/envgen_pkg.sv
// Shared types and constant tables for the multi-voice ADSR envelope engine.
package envgen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_t;

  // Attack period in strobes per step
  function automatic logic [12:0] attack_period(input logic [3:0] code);
    logic [12:0] p;
    case (code)
      4'd0:    p = 13'd1;
      4'd1:    p = 13'd2;
      4'd2:    p = 13'd3;
      4'd3:    p = 13'd4;
      4'd4:    p = 13'd7;
      4'd5:    p = 13'd10;
      4'd6:    p = 13'd13;
      4'd7:    p = 13'd15;
      4'd8:    p = 13'd19;
      4'd9:    p = 13'd47;
      4'd10:   p = 13'd94;
      4'd11:   p = 13'd150;
      4'd12:   p = 13'd188;
      4'd13:   p = 13'd562;
      4'd14:   p = 13'd938;
      4'd15:   p = 13'd1500;
      default: p = 13'd1;
    endcase
    return p;
  endfunction

  function automatic logic [12:0] dr_period(input logic [3:0] code);
    logic [12:0] p;
    case (code)
      4'd0:    p = 13'd1;
      4'd1:    p = 13'd4;
      4'd2:    p = 13'd9;
      4'd3:    p = 13'd14;
      4'd4:    p = 13'd21;
      4'd5:    p = 13'd32;
      4'd6:    p = 13'd38;
      4'd7:    p = 13'd45;
      4'd8:    p = 13'd56;
      4'd9:    p = 13'd141;
      4'd10:   p = 13'd281;
      4'd11:   p = 13'd450;
      4'd12:   p = 13'd562;
      4'd13:   p = 13'd1688;
      4'd14:   p = 13'd2812;
      4'd15:   p = 13'd4500;
      default: p = 13'd1;
    endcase
    return p;
  endfunction

  // Nibble replicated MSB-first, keeping the top `width` bits
  function automatic logic [15:0] sus_scale(input logic [3:0] code, input int width);
    logic [15:0] rep;
    rep = {code, code, code, code};
    return rep >> (16 - width);
  endfunction

endpackage

// File: rtl/envgen_step.sv
// Combinational next-state/envelope/counter logic for one voice slot.
module envgen_step
  import envgen_pkg::*;
#(
  parameter int ENV_W     = 12,
  parameter int EXP_SHIFT = 5
) (
  input  env_state_t       state,
  input  logic [ENV_W-1:0] env,
  input  logic [12:0]      cnt,
  input  logic [3:0]       attack,
  input  logic [3:0]       decay,
  input  logic [3:0]       sustain,
  input  logic [3:0]       release_rate,
  input  logic             exp_mode,
  input  logic             hard_restart,
  input  logic             rise,
  input  logic             fall,
  output env_state_t       state_nxt,
  output logic [ENV_W-1:0] env_nxt,
  output logic [12:0]      cnt_nxt
);

  localparam logic [ENV_W-1:0] MAX   = {ENV_W{1'b1}};
  localparam logic [ENV_W:0]   MAX_X = {1'b0, {ENV_W{1'b1}}};
  localparam logic [ENV_W:0]   LSTEP = (ENV_W+1)'(1'b1) << (ENV_W - 8);

  logic [ENV_W-1:0] sus_lvl_s;
  logic [ENV_W:0]   env_x_s, sus_x_s, exp_raw_s, exp_step_s, dec_step_s;
  logic [ENV_W:0]   sub_s, sum_s;
  logic             under_s, step_s;
  logic [12:0]      per_s, cnt_inc_s;
  logic [ENV_W-1:0] attack_env_s, decay_env_s, rel_env_s;

  assign sus_lvl_s  = ENV_W'(sus_scale(sustain, ENV_W));
  assign env_x_s    = {1'b0, env};
  assign sus_x_s    = {1'b0, sus_lvl_s};
  assign exp_raw_s  = {1'b0, env >> EXP_SHIFT};
  assign exp_step_s = (exp_raw_s == '0) ? (ENV_W+1)'(1'b1) : exp_raw_s;
  assign dec_step_s = exp_mode ? exp_step_s : LSTEP;

  // One extra bit keeps the subtraction from wrapping; under_s flags a would-be negative
  assign sub_s   = env_x_s - dec_step_s;
  assign under_s = (dec_step_s > env_x_s);
  assign sum_s   = env_x_s + LSTEP;

  assign attack_env_s = (sum_s > MAX_X) ? MAX : sum_s[ENV_W-1:0];
  assign decay_env_s  = (under_s || (sub_s < sus_x_s)) ? sus_lvl_s : sub_s[ENV_W-1:0];
  assign rel_env_s    = under_s ? {ENV_W{1'b0}} : sub_s[ENV_W-1:0];

  assign per_s     = (state == ST_ATTACK) ? attack_period(attack)
                   : dr_period((state == ST_DECAY) ? decay : release_rate);
  assign step_s    = (cnt >= (per_s - 13'd1));
  assign cnt_inc_s = step_s ? 13'd0 : (cnt + 13'd1);

  // Gate edges override the per-state action
  always_comb begin
    state_nxt = state;
    env_nxt   = env;
    cnt_nxt   = cnt;
    if (rise) begin
      state_nxt = ST_ATTACK;
      cnt_nxt   = 13'd0;
      if (hard_restart) begin
        env_nxt = {ENV_W{1'b0}};
      end else begin
        env_nxt = env;
      end
    end else if (fall) begin
      state_nxt = ST_RELEASE;
      cnt_nxt   = 13'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          env_nxt = {ENV_W{1'b0}};
          cnt_nxt = 13'd0;
        end
        ST_ATTACK: begin
          cnt_nxt = cnt_inc_s;
          if (step_s && (env == MAX)) begin
            state_nxt = ST_DECAY;
          end else if (step_s) begin
            env_nxt = attack_env_s;
          end else begin
            env_nxt = env;
          end
        end
        ST_DECAY: begin
          if (env <= sus_lvl_s) begin
            env_nxt   = sus_lvl_s;
            state_nxt = ST_SUSTAIN;
            cnt_nxt   = 13'd0;
          end else begin
            cnt_nxt = cnt_inc_s;
            if (step_s) begin
              env_nxt = decay_env_s;
            end else begin
              env_nxt = env;
            end
          end
        end
        ST_SUSTAIN: begin
          env_nxt = sus_lvl_s;
          cnt_nxt = 13'd0;
        end
        ST_RELEASE: begin
          if (env == {ENV_W{1'b0}}) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = 13'd0;
          end else begin
            cnt_nxt = cnt_inc_s;
            if (step_s) begin
              env_nxt = rel_env_s;
            end else begin
              env_nxt = env;
            end
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          env_nxt   = {ENV_W{1'b0}};
          cnt_nxt   = 13'd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/envgen_multi.sv
// Time-multiplexed ADSR engine: one shared step datapath walks all voices once per sample strobe.
module envgen_multi
  import envgen_pkg::*;
#(
  parameter int VOICES    = 4,
  parameter int ENV_W     = 12,
  parameter int EXP_SHIFT = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_strobe,
  input  logic [3:0]        attack       [VOICES],
  input  logic [3:0]        decay        [VOICES],
  input  logic [3:0]        sustain      [VOICES],
  input  logic [3:0]        release_rate [VOICES],
  input  logic [VOICES-1:0] exp_mode,
  input  logic [VOICES-1:0] hard_restart,
  input  logic [VOICES-1:0] gate,
  output logic [ENV_W-1:0]  env_out      [VOICES],
  output logic [VOICES-1:0] active,
  output logic              busy,
  output logic              scan_done,
  output logic              overrun
);

  localparam int            IW       = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(VOICES - 1);

  logic [IW-1:0]     idx_r;
  env_state_t        state_r    [VOICES];
  logic [12:0]       cnt_r      [VOICES];
  logic [VOICES-1:0] gate_prev_r;

  env_state_t        state_nxt_s;
  logic [ENV_W-1:0]  env_nxt_s;
  logic [12:0]       cnt_nxt_s;
  logic              rise_s, fall_s, start_s, last_next_s;

  assign rise_s  = gate[idx_r] & ~gate_prev_r[idx_r];
  assign fall_s  = ~gate[idx_r] & gate_prev_r[idx_r];
  assign start_s = sample_strobe & ~busy;
  // scan_done is registered, so it is armed one cycle before the last slot
  assign last_next_s = (busy && ((int'(idx_r) + 2) == VOICES)) || (start_s && (VOICES == 1));

  envgen_step #(
    .ENV_W     (ENV_W),
    .EXP_SHIFT (EXP_SHIFT)
  ) u_step (
    .state        (state_r[idx_r]),
    .env          (env_out[idx_r]),
    .cnt          (cnt_r[idx_r]),
    .attack       (attack[idx_r]),
    .decay        (decay[idx_r]),
    .sustain      (sustain[idx_r]),
    .release_rate (release_rate[idx_r]),
    .exp_mode     (exp_mode[idx_r]),
    .hard_restart (hard_restart[idx_r]),
    .rise         (rise_s),
    .fall         (fall_s),
    .state_nxt    (state_nxt_s),
    .env_nxt      (env_nxt_s),
    .cnt_nxt      (cnt_nxt_s)
  );

  // Scan control: voice index, busy window, done pulse and sticky overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r     <= {IW{1'b0}};
      busy      <= 1'b0;
      scan_done <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      scan_done <= last_next_s;
      if (sample_strobe && busy) begin
        overrun <= 1'b1;
      end
      if (busy) begin
        if (idx_r == LAST_IDX) begin
          busy  <= 1'b0;
          idx_r <= {IW{1'b0}};
        end else begin
          idx_r <= idx_r + IW'(1'b1);
        end
      end else if (start_s) begin
        busy  <= 1'b1;
        idx_r <= {IW{1'b0}};
      end
    end
  end

  // Per-voice state: only the voice in the current slot is written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < VOICES; v++) begin
        state_r[v] <= ST_IDLE;
        cnt_r[v]   <= 13'd0;
        env_out[v] <= {ENV_W{1'b0}};
      end
      gate_prev_r <= {VOICES{1'b0}};
      active      <= {VOICES{1'b0}};
    end else if (busy) begin
      state_r[idx_r]     <= state_nxt_s;
      cnt_r[idx_r]       <= cnt_nxt_s;
      env_out[idx_r]     <= env_nxt_s;
      gate_prev_r[idx_r] <= gate[idx_r];
      active[idx_r]      <= (state_nxt_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_envgen_multi.sv
// Directed, table-driven bench for envgen_multi (VOICES=4, ENV_W=12, EXP_SHIFT=5).
module tb_envgen_multi;

  localparam int VOICES = 4;
  localparam int ENV_W  = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sample_strobe = 1'b0;
  logic [3:0]        attack       [VOICES];
  logic [3:0]        decay        [VOICES];
  logic [3:0]        sustain      [VOICES];
  logic [3:0]        release_rate [VOICES];
  logic [VOICES-1:0] exp_mode = '0;
  logic [VOICES-1:0] hard_restart = '0;
  logic [VOICES-1:0] gate = '0;
  logic [ENV_W-1:0]  env_out      [VOICES];
  logic [VOICES-1:0] active;
  logic              busy, scan_done, overrun;

  int checks = 0;
  int errors = 0;

  envgen_multi #(.VOICES(VOICES), .ENV_W(ENV_W), .EXP_SHIFT(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_strobe(sample_strobe),
    .attack       (attack),
    .decay        (decay),
    .sustain      (sustain),
    .release_rate (release_rate),
    .exp_mode     (exp_mode),
    .hard_restart (hard_restart),
    .gate         (gate),
    .env_out      (env_out),
    .active       (active),
    .busy         (busy),
    .scan_done    (scan_done),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        g;
    logic [3:0]  sus;
    int          n;
    logic [11:0] env;
    logic        act;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic strobe();
    @(negedge clk) sample_strobe = 1'b1;
    @(negedge clk) sample_strobe = 1'b0;
    repeat (VOICES + 1) @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) strobe();
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, e_next, st, guard;
    for (int v = 0; v < VOICES; v++) begin
      attack[v] = 4'd0; decay[v] = 4'd0; sustain[v] = 4'd0; release_rate[v] = 4'd0;
    end
    sustain[0] = 4'd8;

    //              gate  sus    n    env      active
    vecs[0]  = '{1'b1, 4'h8,   1, 12'h000, 1'b1};
    vecs[1]  = '{1'b1, 4'h8,   1, 12'h010, 1'b1};
    vecs[2]  = '{1'b1, 4'h8,  99, 12'h640, 1'b1};
    vecs[3]  = '{1'b1, 4'h8, 155, 12'hFF0, 1'b1};
    vecs[4]  = '{1'b1, 4'h8,   1, 12'hFFF, 1'b1};
    vecs[5]  = '{1'b1, 4'h8,   1, 12'hFFF, 1'b1};
    vecs[6]  = '{1'b1, 4'h8,   1, 12'hFEF, 1'b1};
    vecs[7]  = '{1'b1, 4'h8, 118, 12'h88F, 1'b1};
    vecs[8]  = '{1'b1, 4'h8,   1, 12'h888, 1'b1};
    vecs[9]  = '{1'b1, 4'h8,   1, 12'h888, 1'b1};
    vecs[10] = '{1'b1, 4'h8,   5, 12'h888, 1'b1};
    vecs[11] = '{1'b1, 4'hC,   1, 12'hCCC, 1'b1};
    vecs[12] = '{1'b1, 4'h8,   1, 12'h888, 1'b1};
    vecs[13] = '{1'b0, 4'h8,   1, 12'h888, 1'b1};
    vecs[14] = '{1'b0, 4'h8,   1, 12'h878, 1'b1};
    vecs[15] = '{1'b0, 4'h8, 135, 12'h008, 1'b1};
    vecs[16] = '{1'b0, 4'h8,   1, 12'h000, 1'b1};
    vecs[17] = '{1'b0, 4'h8,   1, 12'h000, 1'b0};

    // Reset state
    do_reset();
    for (int v = 0; v < VOICES; v++) check($sformatf("reset env%0d", v), env_out[v], 0);
    check("reset active", active, 0);
    check("reset busy", busy, 0);
    check("reset scan_done", scan_done, 0);
    check("reset overrun", overrun, 0);

    // Scan timing: strobe sampled at the edge ending cycle t; negedge k lies in cycle t+k
    @(negedge clk) sample_strobe = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      sample_strobe = 1'b0;
      check($sformatf("busy t+%0d", k), busy, (k <= 4) ? 1 : 0);
      check($sformatf("scan_done t+%0d", k), scan_done, (k == 4) ? 1 : 0);
      check($sformatf("overrun t+%0d", k), overrun, 0);
    end

    // Linear ADSR on voice 0
    for (int i = 0; i < 18; i++) begin
      gate[0] = vecs[i].g;
      sustain[0] = vecs[i].sus;
      run(vecs[i].n);
      check($sformatf("vec%0d env0", i), env_out[0], vecs[i].env);
      check($sformatf("vec%0d active0", i), active[0], vecs[i].act);
    end

    // Exponential release from 0x800
    exp_mode[0] = 1'b1;
    gate[0] = 1'b1;
    run(1 + 128);
    check("exp attack 0x800", env_out[0], 12'h800);
    gate[0] = 1'b0;
    run(1);
    check("exp fall hold", env_out[0], 12'h800);
    run(1);
    check("exp first step", env_out[0], 12'h7C0);
    e = 'h7C0;
    guard = 0;
    while (e != 0 && guard < 400) begin
      st = e >> 5;
      if (st == 0) st = 1;
      e_next = e - st;
      if (e_next < 0) e_next = 0;
      run(1);
      check($sformatf("exp step %0d", guard), env_out[0], e_next);
      e = e_next;
      guard++;
    end
    run(1);
    check("exp idle env", env_out[0], 0);
    check("exp idle active", active[0], 0);

    // Retrigger mid-release, soft then hard
    exp_mode[0] = 1'b0;
    hard_restart[0] = 1'b0;
    gate[0] = 1'b1;
    run(1 + 49);
    check("retrig attack 0x310", env_out[0], 12'h310);
    gate[0] = 1'b0; run(1);
    check("retrig fall", env_out[0], 12'h310);
    run(1);
    check("retrig release 0x300", env_out[0], 12'h300);
    gate[0] = 1'b1; run(1);
    check("soft rise keeps", env_out[0], 12'h300);
    run(1);
    check("soft climbs", env_out[0], 12'h310);
    hard_restart[0] = 1'b1;
    gate[0] = 1'b0; run(2);
    check("hard pre 0x300", env_out[0], 12'h300);
    gate[0] = 1'b1; run(1);
    check("hard rise zero", env_out[0], 12'h000);
    run(1);
    check("hard climbs", env_out[0], 12'h010);
    check("hard active", active[0], 1);

    // Reset landing mid-scan
    @(negedge clk) sample_strobe = 1'b1;
    @(negedge clk) sample_strobe = 1'b0;
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("midscan busy", busy, 0);
    check("midscan env0", env_out[0], 0);
    check("midscan active", active, 0);
    gate = '0;
    hard_restart = '0;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    // Independence and overrun: voice 1 period 2, voice 3 period 1
    attack[1] = 4'd1;
    attack[3] = 4'd0;
    gate[1] = 1'b1;
    gate[3] = 1'b1;
    @(negedge clk) sample_strobe = 1'b1;
    @(negedge clk) sample_strobe = 1'b0;
    check("ovr busy t+1", busy, 1);
    @(negedge clk) sample_strobe = 1'b1;
    check("ovr active1 t+2", active[1], 0);
    @(negedge clk) sample_strobe = 1'b0;
    check("ovr active1 t+3", active[1], 1);
    check("ovr active3 t+3", active[3], 0);
    check("ovr set", overrun, 1);
    @(negedge clk);
    check("ovr scan_done t+4", scan_done, 1);
    check("ovr active3 t+4", active[3], 0);
    @(negedge clk);
    check("ovr busy t+5", busy, 0);
    check("ovr active3 t+5", active[3], 1);
    @(negedge clk);
    check("ovr no rescan t+6", busy, 0);
    check("ovr no rescan done", scan_done, 0);
    run(9);
    check("indep v1 m9", env_out[1], 16 * 4);
    check("indep v3 m9", env_out[3], 16 * 9);
    gate[3] = 1'b0;
    run(10);
    check("indep v1 m19", env_out[1], 16 * 9);
    check("indep v3 released", env_out[3], 0);
    check("indep v3 still active", active[3], 1);
    run(1);
    check("indep v1 m20", env_out[1], 16 * 10);
    check("indep v3 idle", active[3], 0);
    check("indep v0 env", env_out[0], 0);
    check("indep v2 env", env_out[2], 0);
    check("indep active", active, 4'b0010);
    check("overrun sticky", overrun, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
